// File: rtl/stage_f.sv
// Fetch stage: owns the fetch PC, drives the synchronous IM and feeds the F/D register.
// Optional AdEL detection on the fetch PC is built when STAGE_F_ADEL_CHECK_EN is defined.
module stage_f #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_d,
  input  logic [31:0] epc,
  input  logic        branch_d,
  input  logic        taken_d,
  input  logic [31:0] target_d,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [4:0]  exc_out,
  output logic        slot_out,
  output logic        flush_out,
  output logic [31:0] jumpto_out
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;

  always_comb begin
    pc_next = pc_reg + 32'd4;
    if (rst)
      pc_next = RESET_PC;
    else if (req)
      pc_next = HANDLER_PC;
    else if (stall)
      pc_next = pc_reg;
    else if (eret_d)
      pc_next = epc;
    else if (taken_d)
      pc_next = target_d;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc_reg <= RESET_PC;
    else
      pc_reg <= pc_next;
  end

  // The IM registers its address, so presenting pc_next lines its data up with pc_reg.
  assign imem_addr  = pc_next;
  assign pc_out     = pc_reg;
  assign slot_out   = branch_d;
  assign flush_out  = eret_d & ~stall & ~req;
  assign jumpto_out = epc;

`ifdef STAGE_F_ADEL_CHECK_EN
  logic adel;
  assign adel      = (pc_reg[1:0] != 2'b00) || (pc_reg < TEXT_LO) || (pc_reg > TEXT_HI);
  assign exc_out   = adel ? 5'd4 : 5'd0;
  assign instr_out = adel ? 32'd0 : imem_rdata;
`else
  logic unused_text_bounds;
  assign unused_text_bounds = ^{TEXT_LO, TEXT_HI};
  assign exc_out   = 5'd0;
  assign instr_out = imem_rdata;
`endif

endmodule

// File: tb/tb_stage_f.sv
// Self-checking bench for stage_f: directed test-plan checks plus randomized traffic against a PC model.
module tb_stage_f;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0, req = 1'b0, eret_d = 1'b0, branch_d = 1'b0, taken_d = 1'b0;
  logic [31:0] epc = 32'd0, target_d = 32'd0;
  logic [31:0] imem_addr, imem_rdata, instr_out, pc_out, jumpto_out;
  logic [4:0]  exc_out;
  logic        slot_out, flush_out;

  int checks = 0;
  int errors = 0;

  stage_f dut (
    .clk(clk), .rst(rst), .stall(stall), .req(req), .eret_d(eret_d), .epc(epc),
    .branch_d(branch_d), .taken_d(taken_d), .target_d(target_d),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_out(pc_out), .exc_out(exc_out), .slot_out(slot_out),
    .flush_out(flush_out), .jumpto_out(jumpto_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    case (a)
      32'h0000_3000: return 32'h1111_1111;
      32'h0000_3004: return 32'h2222_2222;
      32'h0000_3008: return 32'h3333_3333;
      32'h0000_300C: return 32'h4444_4444;
      default:       return a ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  // Synchronous instruction memory
  always @(posedge clk) imem_rdata <= im_word(imem_addr);

  function automatic logic [4:0] exp_exc(input logic [31:0] a);
`ifdef STAGE_F_ADEL_CHECK_EN
    if (a % 4 != 0 || a < TEXT_LO || a > TEXT_HI) return 5'd4;
`endif
    return 5'd0;
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    return (exp_exc(a) != 5'd0) ? 32'd0 : im_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req_v, $time);
    end
  endtask

  // Reference model: the fetch PC chosen from the priority rules
  logic [31:0] model_pc;
  bit          model_valid = 0;

  function automatic logic [31:0] model_next(input logic [31:0] cur);
    if (rst)     return RESET_PC;
    if (req)     return HANDLER_PC;
    if (stall)   return cur;
    if (eret_d)  return epc;
    if (taken_d) return target_d;
    return cur + 32'd4;
  endfunction

  always @(posedge clk) begin
    if (rst) model_valid <= 1'b1;
    model_pc <= model_next(model_pc);
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("pc_out", pc_out, model_pc);
      chk("instr_out", instr_out, exp_instr(model_pc));
      chk("exc_out", {27'd0, exc_out}, {27'd0, exp_exc(model_pc)});
      chk("imem_addr", imem_addr, model_next(model_pc));
      chk("slot_out", {31'd0, slot_out}, {31'd0, branch_d});
      chk("flush_out", {31'd0, flush_out}, {31'd0, eret_d & ~stall & ~req});
      chk("jumpto_out", jumpto_out, epc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return TEXT_LO;
      1: return TEXT_HI;
      2: return TEXT_HI + 32'd4;
      3: return TEXT_LO - 32'd4;
      4: return 32'h0000_3002;
      5: return 32'hFFFF_FFFC;
      default: return TEXT_LO + 32'd4 * $urandom_range(0, 32'hFFF);
    endcase
  endfunction

  task automatic jump_to(input logic [31:0] a);
    taken_d = 1'b1; target_d = a;
    tick();
    taken_d = 1'b0;
  endtask

  initial begin
    // Reset, then free-running fetch
    tick();
    rst = 1'b0;
    chk("rst_pc", pc_out, 32'h3000);
    chk("rst_instr", instr_out, 32'h1111_1111);
    chk("rst_exc", {27'd0, exc_out}, 32'd0);
    chk("rst_flush", {31'd0, flush_out}, 32'd0);
    tick(); chk("seq_pc1", pc_out, 32'h3004); chk("seq_i1", instr_out, 32'h2222_2222);
    tick(); chk("seq_pc2", pc_out, 32'h3008); chk("seq_i2", instr_out, 32'h3333_3333);
    tick(); chk("seq_pc3", pc_out, 32'h300C); chk("seq_i3", instr_out, 32'h4444_4444);
    chk("seq_exc", {27'd0, exc_out}, 32'd0);

    // Three-cycle stall at 0x3008
    jump_to(32'h3008);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc_out, 32'h3008);
      chk("stall_instr", instr_out, 32'h3333_3333);
    end
    stall = 1'b0;
    tick(); chk("stall_rel_pc", pc_out, 32'h300C);

    // Taken branch at 0x3004
    jump_to(32'h3004);
    branch_d = 1'b1; taken_d = 1'b1; target_d = 32'h3100;
    #1 chk("br_slot", {31'd0, slot_out}, 32'd1);
    tick(); chk("br_pc", pc_out, 32'h3100);
    branch_d = 1'b0; taken_d = 1'b0;

    // eret without and with stall
    eret_d = 1'b1; epc = 32'h3040;
    #1 chk("eret_flush", {31'd0, flush_out}, 32'd1);
    chk("eret_jumpto", jumpto_out, 32'h3040);
    tick(); chk("eret_pc", pc_out, 32'h3040);
    epc = 32'h3200; stall = 1'b1;
    #1 chk("eret_stall_flush", {31'd0, flush_out}, 32'd0);
    tick(); chk("eret_stall_pc", pc_out, 32'h3040);
    eret_d = 1'b0; stall = 1'b0;

    // Exception request beats everything
    req = 1'b1; taken_d = 1'b1; stall = 1'b1; eret_d = 1'b1; target_d = 32'h3500;
    #1 chk("req_flush", {31'd0, flush_out}, 32'd0);
    tick(); chk("req_pc", pc_out, 32'h4180);
    req = 1'b0; taken_d = 1'b0; stall = 1'b0; eret_d = 1'b0;

    // Misaligned and out-of-range targets
    jump_to(32'h3002);
    chk("mis_pc", pc_out, 32'h3002);
`ifdef STAGE_F_ADEL_CHECK_EN
    chk("mis_exc", {27'd0, exc_out}, 32'd4);
    chk("mis_instr", instr_out, 32'd0);
`else
    chk("mis_exc", {27'd0, exc_out}, 32'd0);
    chk("mis_instr", instr_out, 32'h3002 ^ 32'hDEAD_BEEF);
`endif
    jump_to(32'h4000);
    jump_to(32'h7000);
    chk("oor_pc", pc_out, 32'h7000);
`ifdef STAGE_F_ADEL_CHECK_EN
    chk("oor_exc", {27'd0, exc_out}, 32'd4);
    chk("oor_instr", instr_out, 32'd0);
`else
    chk("oor_exc", {27'd0, exc_out}, 32'd0);
    chk("oor_instr", instr_out, 32'h7000 ^ 32'hDEAD_BEEF);
`endif

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      req      = ($urandom_range(0, 15) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      eret_d   = ($urandom_range(0, 9) == 0);
      branch_d = ($urandom_range(0, 3) == 0);
      taken_d  = ($urandom_range(0, 4) == 0);
      epc      = pick_addr();
      target_d = pick_addr();
      tick();
    end
    rst = 1'b0; req = 1'b0; stall = 1'b0; eret_d = 1'b0; branch_d = 1'b0; taken_d = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
